// File: rtl/quick_cpu_pkg.sv
// rtl/quick_cpu_pkg.sv - shared constants and types for the quick CPU memory slave
//   IO_IN_ADDR / IO_OUT_ADDR : memory-mapped port addresses
//   state_t                  : write FSM states
//   OP_*                     : quick core opcode constants (upper nibble of an instruction byte)
package quick_cpu_pkg;

    localparam logic [7:0] IO_IN_ADDR  = 8'hFE;
    localparam logic [7:0] IO_OUT_ADDR = 8'hFF;

    typedef enum logic {
        IDLE    = 1'b0,
        WR_DATA = 1'b1
    } state_t;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_STA = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_SUB = 4'h4;
    localparam logic [3:0] OP_JMP = 4'h5;
    localparam logic [3:0] OP_JZ  = 4'h6;
    localparam logic [3:0] OP_LDI = 4'h7;
    localparam logic [3:0] OP_HLT = 4'hF;

endpackage

// File: rtl/quick_cpu_ram.sv
// rtl/quick_cpu_ram.sv - DEPTH x 8 RAM, one async read port, one sync write port
//   clk            : write clock
//   we/waddr/wdata : synchronous write port
//   raddr/rdata    : asynchronous read port
// Contents have no reset so they survive a controller reset.
module quick_cpu_ram #(
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/quick_cpu_mem.sv
// rtl/quick_cpu_mem.sv - bus slave for the quick CPU core: RAM, IO ports, program loader
//   clk, rst                   : clock, synchronous active-high reset
//   bus_ad/bus_read/bus_write  : core bus (address phase, then data phase for writes)
//   rd_data                    : combinational read data back to the core
//   ld_en/ld_valid/ld_data     : byte-serial program loader (core held in reset)
//   io_in / io_out             : input port at 8'hFE, output register at 8'hFF
//   bus_err                    : sticky protocol-violation flag
module quick_cpu_mem
    import quick_cpu_pkg::*;
#(
    parameter int DEPTH = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] bus_ad,
    input  logic       bus_read,
    input  logic       bus_write,
    output logic [7:0] rd_data,
    input  logic       ld_en,
    input  logic       ld_valid,
    input  logic [7:0] ld_data,
    input  logic [7:0] io_in,
    output logic [7:0] io_out,
    output logic       bus_err
);

    localparam int         AW      = $clog2(DEPTH);
    localparam logic [7:0] DEPTH_B = 8'(DEPTH);

    state_t        state;
    logic [7:0]    wr_addr;
    logic [AW-1:0] ld_ptr;
    logic          ld_en_q;

    logic          ld_start;
    logic [AW-1:0] ld_addr;
    logic          ram_we;
    logic [AW-1:0] ram_waddr;
    logic [7:0]    ram_wdata;
    logic [7:0]    ram_rdata;

    // A fresh load session always begins at address 0, even if a byte
    // arrives in the very first ld_en cycle before ld_ptr has been cleared.
    assign ld_start = ld_en & ~ld_en_q;
    assign ld_addr  = ld_start ? '0 : ld_ptr;

    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = wr_addr[AW-1:0];
        ram_wdata = bus_ad;
        if (!rst) begin
            if (ld_en) begin
                ram_we    = ld_valid;
                ram_waddr = ld_addr;
                ram_wdata = ld_data;
            end else if (state == WR_DATA && wr_addr < DEPTH_B) begin
                ram_we = 1'b1;
            end
        end
    end

    quick_cpu_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (bus_ad[AW-1:0]),
        .rdata (ram_rdata)
    );

    always_comb begin
        rd_data = 8'h00;
        if (bus_read && !ld_en) begin
            if (bus_ad < DEPTH_B) begin
                rd_data = ram_rdata;
            end else if (bus_ad == IO_IN_ADDR) begin
                rd_data = io_in;
            end else if (bus_ad == IO_OUT_ADDR) begin
                rd_data = io_out;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            wr_addr <= 8'h00;
            ld_ptr  <= '0;
            ld_en_q <= 1'b0;
            io_out  <= 8'h00;
            bus_err <= 1'b0;
        end else begin
            ld_en_q <= ld_en;
            if (ld_en) begin
                // Loader owns the RAM; any half-finished bus write is abandoned.
                state <= IDLE;
                if (ld_valid) begin
                    ld_ptr <= ld_addr + 1'b1;
                end else if (ld_start) begin
                    ld_ptr <= '0;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (bus_write) begin
                            wr_addr <= bus_ad;
                            state   <= WR_DATA;
                            if (bus_read) begin
                                bus_err <= 1'b1;
                            end
                        end
                    end
                    WR_DATA: begin
                        // Data phase: bus_ad carries the data; strobes here are a
                        // violation but do not block the commit.
                        if (wr_addr == IO_OUT_ADDR) begin
                            io_out <= bus_ad;
                        end
                        if (bus_read || bus_write) begin
                            bus_err <= 1'b1;
                        end
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
